// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline stages: default widths,
// field bit-offset helpers and the held-entry type.
package pipe_pkg;

   localparam int INSTR_W_DEF = 32;
   localparam int PC_W_DEF    = 16;
   localparam int OPC_W_DEF   = 5;
   localparam int REG_W_DEF   = 5;
   localparam int IMM_W_DEF   = 17;
   localparam int DIR_W_DEF   = 16;
   localparam int DATA_W_DEF  = 32;
   localparam int CNT_W_DEF   = 16;

   // Entry held in the main or skid register at the default widths.
   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [PC_W_DEF-1:0]    pc;
   } ifd_entry_t;

   // Opcode sits at the top of the word; rd, ra, rb follow contiguously below it.
   function automatic int opc_lsb(input int instr_w, input int opc_w);
      return instr_w - opc_w;
   endfunction

   function automatic int rd_lsb(input int instr_w, input int opc_w, input int reg_w);
      return instr_w - opc_w - reg_w;
   endfunction

   function automatic int ra_lsb(input int instr_w, input int opc_w, input int reg_w);
      return instr_w - opc_w - (2 * reg_w);
   endfunction

   function automatic int rb_lsb(input int instr_w, input int opc_w, input int reg_w);
      return instr_w - opc_w - (3 * reg_w);
   endfunction

endpackage

// File: rtl/pipe_ifd_decode.sv
// Combinational instruction field extractor with selectable immediate extension.
// Shared between the IF/ID and ID/EX stages.
module pipe_ifd_decode
   import pipe_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int OPC_W   = OPC_W_DEF,
   parameter int REG_W   = REG_W_DEF,
   parameter int IMM_W   = IMM_W_DEF,
   parameter int DIR_W   = DIR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               sext_en_i,
   output logic [OPC_W-1:0]   opcode_o,
   output logic [REG_W-1:0]   rd_o,
   output logic [REG_W-1:0]   ra_o,
   output logic [REG_W-1:0]   rb_o,
   output logic [DATA_W-1:0]  imm_o,
   output logic [DIR_W-1:0]   dir_o
);

   localparam int OPC_LSB = opc_lsb(INSTR_W, OPC_W);
   localparam int RD_LSB  = rd_lsb(INSTR_W, OPC_W, REG_W);
   localparam int RA_LSB  = ra_lsb(INSTR_W, OPC_W, REG_W);
   localparam int RB_LSB  = rb_lsb(INSTR_W, OPC_W, REG_W);

   logic [IMM_W-1:0] imm_raw_s;

   // Field slicing; the signed cast replicates bit IMM_W-1 when widening.
   always_comb begin
      opcode_o  = instr_i[OPC_LSB +: OPC_W];
      rd_o      = instr_i[RD_LSB +: REG_W];
      ra_o      = instr_i[RA_LSB +: REG_W];
      rb_o      = instr_i[RB_LSB +: REG_W];
      imm_raw_s = instr_i[IMM_W-1:0];
      imm_o     = sext_en_i ? DATA_W'($signed(imm_raw_s)) : DATA_W'(imm_raw_s);
      dir_o     = instr_i[DIR_W-1:0];
   end

endmodule

// File: rtl/pipe_ifd_stage.sv
// IF/ID pipeline register with optional 2-entry skid, flush, field decode
// and a saturating back-pressure counter.
module pipe_ifd_stage
   import pipe_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int PC_W    = PC_W_DEF,
   parameter int OPC_W   = OPC_W_DEF,
   parameter int REG_W   = REG_W_DEF,
   parameter int IMM_W   = IMM_W_DEF,
   parameter int DIR_W   = DIR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SKID    = 1,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   input  logic               sext_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OPC_W-1:0]   out_opcode,
   output logic [REG_W-1:0]   out_rd,
   output logic [REG_W-1:0]   out_ra,
   output logic [REG_W-1:0]   out_rb,
   output logic [DATA_W-1:0]  out_imm,
   output logic [DIR_W-1:0]   out_dir,
   output logic [PC_W-1:0]    out_pc,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } entry_t;

   localparam bit               HAS_SKID = (SKID != 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   entry_t           m_q, m_d, s_q, s_d, in_entry_s;
   logic             m_valid_q, m_valid_d;
   logic             s_valid_q, s_valid_d;
   logic             rdy_q, rdy_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             accept_s, issue_s, in_ready_s;

   // rdy_q is low in reset; with a skid it mirrors the registered ~S.valid.
   always_comb begin
      if (HAS_SKID) begin
         in_ready_s = rdy_q;
      end else begin
         in_ready_s = rdy_q & (~m_valid_q | out_ready);
      end
      accept_s         = in_valid & in_ready_s;
      issue_s          = m_valid_q & out_ready;
      in_entry_s.instr = in_instr;
      in_entry_s.pc    = in_pc;
   end

   // Next-state for main/skid entries: S drains into M before new input.
   always_comb begin
      m_d       = m_q;
      m_valid_d = m_valid_q;
      s_d       = s_q;
      s_valid_d = s_valid_q;
      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!m_valid_q || issue_s) begin
         if (s_valid_q) begin
            m_d       = s_q;
            m_valid_d = 1'b1;
         end else if (accept_s) begin
            m_d       = in_entry_s;
            m_valid_d = 1'b1;
         end else begin
            m_valid_d = 1'b0;
         end
         s_valid_d = 1'b0;
      end else if (accept_s && HAS_SKID) begin
         s_d       = in_entry_s;
         s_valid_d = 1'b1;
      end else begin
         s_valid_d = s_valid_q;
      end
      rdy_d = ~s_valid_d;
   end

   // Saturating count of cycles where a valid output is refused downstream.
   always_comb begin
      if (m_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_q       <= '0;
         s_q       <= '0;
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         rdy_q     <= 1'b0;
         stall_q   <= '0;
      end else begin
         m_q       <= m_d;
         s_q       <= s_d;
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         rdy_q     <= rdy_d;
         stall_q   <= stall_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = m_valid_q;
   assign out_pc    = m_q.pc;
   assign stall_cnt = stall_q;

   pipe_ifd_decode #(
      .INSTR_W (INSTR_W),
      .OPC_W   (OPC_W),
      .REG_W   (REG_W),
      .IMM_W   (IMM_W),
      .DIR_W   (DIR_W),
      .DATA_W  (DATA_W)
   ) u_decode (
      .instr_i   (m_q.instr),
      .sext_en_i (sext_en),
      .opcode_o  (out_opcode),
      .rd_o      (out_rd),
      .ra_o      (out_ra),
      .rb_o      (out_rb),
      .imm_o     (out_imm),
      .dir_o     (out_dir)
   );

endmodule

// File: tb/tb_pipe_ifd_stage.sv
// Scoreboard bench for pipe_ifd_stage: one skid instance (SKID=1) and one
// single-register instance (SKID=0, CNT_W=4).
module tb_pipe_ifd_stage;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        sext_en = 1'b1;
   int          checks = 0;
   int          failures = 0;

   logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0;
   logic [31:0] in_instr0 = 32'd0, out_imm0;
   logic [15:0] in_pc0 = 16'd0, out_dir0, out_pc0, stall_cnt0;
   logic [4:0]  out_opcode0, out_rd0, out_ra0, out_rb0;

   logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
   logic [31:0] in_instr1 = 32'd0, out_imm1;
   logic [15:0] in_pc1 = 16'd0, out_dir1, out_pc1;
   logic [3:0]  stall_cnt1;
   logic [4:0]  out_opcode1, out_rd1, out_ra1, out_rb1;

   ifd_entry_t  sb0[$];
   ifd_entry_t  sb1[$];

   always #5 clk = ~clk;

   pipe_ifd_stage dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_instr(in_instr0), .in_pc(in_pc0), .flush(flush), .sext_en(sext_en),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_opcode(out_opcode0),
      .out_rd(out_rd0), .out_ra(out_ra0), .out_rb(out_rb0), .out_imm(out_imm0),
      .out_dir(out_dir0), .out_pc(out_pc0), .stall_cnt(stall_cnt0)
   );

   pipe_ifd_stage #(.SKID(0), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_instr(in_instr1), .in_pc(in_pc1), .flush(flush), .sext_en(sext_en),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_opcode(out_opcode1),
      .out_rd(out_rd1), .out_ra(out_ra1), .out_rb(out_rb1), .out_imm(out_imm1),
      .out_dir(out_dir1), .out_pc(out_pc1), .stall_cnt(stall_cnt1)
   );

   // Reference decode: {opcode, rd, ra, rb, imm, dir, pc}.
   function automatic logic [83:0] model(input logic [31:0] ins, input logic [15:0] pc,
                                         input logic sx);
      logic [31:0] imm;
      imm = {15'd0, ins[16:0]};
      if (sx && ins[16]) imm[31:17] = 15'h7FFF;
      return {ins[31:27], ins[26:22], ins[21:17], ins[16:12], imm, ins[15:0], pc};
   endfunction

   // Scoreboard for dut0: occupancy, in-order issue, flush drop, accept push.
   always @(negedge clk) begin
      ifd_entry_t  e;
      logic [83:0] act;
      logic [83:0] exp_v;
      if (!rst_n) begin
         sb0.delete();
      end else begin
         checks++;
         if (out_valid0 !== (sb0.size() != 0)) begin
            failures++;
            $display("FAIL sb0_valid: out_valid=%0b held=%0d", out_valid0, sb0.size());
         end
         if (out_valid0 && out_ready0 && sb0.size() != 0) begin
            e     = sb0.pop_front();
            act   = {out_opcode0, out_rd0, out_ra0, out_rb0, out_imm0, out_dir0, out_pc0};
            exp_v = model(e.instr, e.pc, sext_en);
            checks++;
            if (act !== exp_v) begin
               failures++;
               $display("FAIL sb0_issue: got %h expected %h", act, exp_v);
            end
         end
         if (flush) begin
            sb0.delete();
         end else if (in_valid0 && in_ready0) begin
            e.instr = in_instr0;
            e.pc    = in_pc0;
            sb0.push_back(e);
         end
      end
   end

   // Scoreboard for dut1, same rules.
   always @(negedge clk) begin
      ifd_entry_t  e;
      logic [83:0] act;
      logic [83:0] exp_v;
      if (!rst_n) begin
         sb1.delete();
      end else begin
         checks++;
         if (out_valid1 !== (sb1.size() != 0)) begin
            failures++;
            $display("FAIL sb1_valid: out_valid=%0b held=%0d", out_valid1, sb1.size());
         end
         if (out_valid1 && out_ready1 && sb1.size() != 0) begin
            e     = sb1.pop_front();
            act   = {out_opcode1, out_rd1, out_ra1, out_rb1, out_imm1, out_dir1, out_pc1};
            exp_v = model(e.instr, e.pc, sext_en);
            checks++;
            if (act !== exp_v) begin
               failures++;
               $display("FAIL sb1_issue: got %h expected %h", act, exp_v);
            end
         end
         if (flush) begin
            sb1.delete();
         end else if (in_valid1 && in_ready1) begin
            e.instr = in_instr1;
            e.pc    = in_pc1;
            sb1.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [83:0] act;
      rst_n = 1'b0; in_valid0 = 1'b1; in_instr0 = 32'hDEADBEEF; in_pc0 = 16'h1234;
      in_valid1 = 1'b1; in_instr1 = 32'hCAFEF00D;
      repeat (3) tick();
      act = {out_opcode0, out_rd0, out_ra0, out_rb0, out_imm0, out_dir0, out_pc0};
      checks++;
      if (out_valid0 !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", out_valid0); end
      checks++;
      if (act !== 84'd0) begin failures++; $display("FAIL rst_fields: got %h expected 0", act); end
      checks++;
      if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
         failures++; $display("FAIL rst_ready: got %0b/%0b expected 0/0", in_ready0, in_ready1);
      end
      checks++;
      if (stall_cnt0 !== 16'd0) begin failures++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt0); end
      rst_n = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0;
      tick();
      checks++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         failures++; $display("FAIL rel_ready: got %0b/%0b expected 1/1", in_ready0, in_ready1);
      end
   endtask

   task automatic test_stream();
      out_ready0 = 1'b1;
      in_valid0 = 1'b1; in_instr0 = 32'h2A4A3005; in_pc0 = 16'h0010;
      tick();
      in_valid0 = 1'b0;
      checks++;
      if ({out_opcode0, out_rd0, out_ra0, out_rb0} !== {5'h05, 5'h09, 5'h05, 5'h03}) begin
         failures++;
         $display("FAIL stream_regs: got %h %h %h %h expected 05 09 05 03",
                  out_opcode0, out_rd0, out_ra0, out_rb0);
      end
      checks++;
      if (out_imm0 !== 32'h00003005 || out_dir0 !== 16'h3005 || out_pc0 !== 16'h0010) begin
         failures++;
         $display("FAIL stream_imm: got %h %h %h expected 00003005 3005 0010", out_imm0, out_dir0, out_pc0);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         in_valid0 = 1'b1; in_instr0 = $urandom(); in_pc0 = 16'h0100 + 16'(i * 4);
         tick();
         checks++;
         if (out_valid0 !== 1'b1 || in_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL stream_rate%0d: got valid=%0b ready=%0b expected 1/1", i, out_valid0, in_ready0);
         end
      end
      in_valid0 = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready0 = 1'b0;
      in_valid0 = 1'b1; in_instr0 = 32'h11111111; in_pc0 = 16'h0A00;
      tick();
      in_instr0 = 32'h22222222; in_pc0 = 16'h0B00;
      tick();
      in_valid0 = 1'b0;
      checks++;
      if (in_ready0 !== 1'b0) begin failures++; $display("FAIL bp_ready: got %0b expected 0", in_ready0); end
      repeat (2) tick();
      checks++;
      if (out_valid0 !== 1'b1 || out_pc0 !== 16'h0A00 || out_opcode0 !== 5'h02) begin
         failures++; $display("FAIL bp_hold: got pc=%h opc=%h expected 0a00 02", out_pc0, out_opcode0);
      end
      checks++;
      if (stall_cnt0 !== 16'd3) begin failures++; $display("FAIL bp_stall: got %0d expected 3", stall_cnt0); end
      out_ready0 = 1'b1;
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || out_pc0 !== 16'h0B00 || in_ready0 !== 1'b1) begin
         failures++;
         $display("FAIL bp_next: got v=%0b pc=%h r=%0b expected 1 0b00 1", out_valid0, out_pc0, in_ready0);
      end
      tick();
      checks++;
      if (out_valid0 !== 1'b0 || stall_cnt0 !== 16'd3) begin
         failures++; $display("FAIL bp_drain: got v=%0b cnt=%0d expected 0 3", out_valid0, stall_cnt0);
      end
   endtask

   task automatic test_flush();
      out_ready0 = 1'b0;
      in_valid0 = 1'b1; in_instr0 = 32'h33333333; in_pc0 = 16'h0C00;
      tick();
      in_instr0 = 32'h44444444; in_pc0 = 16'h0D00;
      tick();
      in_instr0 = 32'h55555555; in_pc0 = 16'h0E00; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid0 = 1'b0;
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
         failures++; $display("FAIL flush_state: got v=%0b r=%0b expected 0 1", out_valid0, in_ready0);
      end
      out_ready0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid0 !== 1'b0) begin failures++; $display("FAIL flush_ghost%0d: got 1 expected 0", i); end
      end
      checks++;
      if (stall_cnt0 !== 16'd5) begin failures++; $display("FAIL flush_stall: got %0d expected 5", stall_cnt0); end
   endtask

   task automatic test_imm();
      out_ready0 = 1'b0;
      in_valid0 = 1'b1; in_instr0 = 32'h00010000; in_pc0 = 16'h0F00;
      tick();
      in_valid0 = 1'b0;
      sext_en = 1'b1;
      #1;
      checks++;
      if (out_imm0 !== 32'hFFFF0000) begin failures++; $display("FAIL imm_sext: got %h expected ffff0000", out_imm0); end
      sext_en = 1'b0;
      #1;
      checks++;
      if (out_imm0 !== 32'h00010000) begin failures++; $display("FAIL imm_zext: got %h expected 00010000", out_imm0); end
      out_ready0 = 1'b1;
      tick();
      sext_en = 1'b1;
   endtask

   task automatic test_skid0();
      out_ready1 = 1'b0;
      in_valid1 = 1'b1; in_instr1 = $urandom(); in_pc1 = 16'h2000;
      tick();
      in_instr1 = $urandom(); in_pc1 = 16'h2004;
      repeat (20) tick();
      checks++;
      if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1) begin
         failures++; $display("FAIL s0_block: got r=%0b v=%0b expected 0 1", in_ready1, out_valid1);
      end
      checks++;
      if (stall_cnt1 !== 4'd15) begin failures++; $display("FAIL s0_sat: got %0d expected 15", stall_cnt1); end
      out_ready1 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (out_valid1 !== 1'b1 || in_ready1 !== 1'b1 || out_pc1 !== 16'h2000 + 16'(k * 4)) begin
            failures++;
            $display("FAIL s0_bubble%0d: got v=%0b r=%0b pc=%h expected 1 1 %h",
                     k, out_valid1, in_ready1, out_pc1, 16'h2000 + 16'(k * 4));
         end
         in_instr1 = $urandom(); in_pc1 = 16'h2000 + 16'((k + 1) * 4);
      end
      in_valid1 = 1'b0;
      tick();
      checks++;
      if (stall_cnt1 !== 4'd15) begin failures++; $display("FAIL s0_hold: got %0d expected 15", stall_cnt1); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_back_to_back();
      test_flush();
      test_imm();
      test_skid0();
      tick();
      checks++;
      if (sb0.size() != 0 || sb1.size() != 0) begin
         failures++; $display("FAIL sb_leftover: got %0d/%0d expected 0/0", sb0.size(), sb1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ifd_stage.md
Name: pipe_ifd_stage

Overview:
Parametrised IF/ID pipeline stage between fetch and decode/register-read. It carries the 32-bit instruction and its fetch PC over a valid/ready handshake, with an optional 2-entry skid buffer. It supports flush for branch redirects and selectable sign- or zero-extension of the immediate. It extracts opcode, destination, source-A, source-B, immediate and direct-address fields, and counts back-pressure cycles for performance debug.

Parameters:
INSTR_W, 32, instruction width
PC_W, 16, fetch PC width
OPC_W, 5, opcode width; field occupies instr[INSTR_W-1 -: OPC_W]
REG_W, 5, register-address width; rd, ra and rb packed contiguously below the opcode, in that order
IMM_W, 17, immediate field width, taken from instr[IMM_W-1:0]
DIR_W, 16, direct-address field width, taken from instr[DIR_W-1:0]
DATA_W, 32, extended immediate width (DATA_W >= IMM_W)
SKID, 1, 1 = 2-entry skid (registered in_ready); 0 = single register (combinational in_ready)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept
in_instr  in  INSTR_W  instruction word
in_pc  in  PC_W  PC of in_instr
flush  in  1  discard all held and incoming instructions
sext_en  in  1  1 = sign-extend immediate, 0 = zero-extend
out_valid  out  1  decoded instruction available
out_ready  in  1  downstream accepts
out_opcode  out  OPC_W  opcode field
out_rd  out  REG_W  destination register
out_ra  out  REG_W  source A register
out_rb  out  REG_W  source B register
out_imm  out  DATA_W  extended immediate
out_dir  out  DIR_W  direct address / branch target
out_pc  out  PC_W  PC of the held instruction
stall_cnt  out  CNT_W  saturating back-pressure cycle count

Behaviour:
- Single clock domain. Reset is synchronous, active low, and has priority over every other input.
- Reset values: out_valid=0, stall_cnt=0, main register (M) and skid register (S) instr/pc = 0, so all field outputs are 0. in_ready=0 while rst_n=0 and 1 in the first cycle after release.
- Transfers: accept = in_valid & in_ready; issue = out_valid & out_ready. Latency is 1 cycle from accept to out_valid, with full throughput of 1 per cycle.
- SKID=1: in_ready = ~S.valid (registered).
  - If M is empty or issue occurs: M loads from S if S.valid, else from the input on accept; S is then cleared.
  - If accept occurs while M holds and there is no issue: the word goes to S, and in_ready drops the next cycle.
  - Ordering is strictly FIFO. S is never written while full.
- SKID=0: in_ready = ~out_valid | out_ready (combinational). S is absent.
- While out_valid=1 and out_ready=0, M is stable: instr, pc and the decoded fields must not change.
- Flush:
  - On a flush cycle, the M and S valids clear next edge and any accept in that cycle is dropped.
  - Data registers may retain old values; only the valids matter.
  - in_ready=1 the cycle after a flush.
  - An issue coinciding with flush still counts as consumed downstream.
- Decode: combinational from M contents.
  - out_imm = M.instr[IMM_W-1:0], extended to DATA_W. Sign extension uses bit IMM_W-1 when sext_en=1; otherwise zeros.
  - sext_en is sampled combinationally, not stored.
- stall_cnt: increments each cycle with out_valid & ~out_ready. It saturates at 2^CNT_W-1 and clears only on reset; flush does not clear it.

Decomposition:
- Shared package pipe_pkg: default width constants, opcode/rd/ra/rb bit-offset functions derived from INSTR_W/OPC_W/REG_W, and a struct {instr, pc} type for M/S entries.
- One sub-module, pipe_ifd_decode: combinational field extractor with immediate extension. It is reused later by the ID/EX stage.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, all fields 0, in_ready=0. Release -> in_ready=1 next cycle.
- Stream: out_ready=1, send instr 0x2A4A3005 at pc 0x0010 -> next cycle out_opcode=0x05, out_rd=0x09, out_ra=0x05, out_rb=0x03, out_imm=0x00003005, out_dir=0x3005. Throughput must be 1/cycle over 8 words.
- Back-pressure (SKID=1): hold out_ready=0, send A then B -> in_ready=0 after B. Output holds A. Release out_ready -> A then B on consecutive cycles. stall_cnt equals the number of stalled cycles.
- Flush with M and S full, plus in_valid=1 that cycle -> out_valid=0 next cycle, in_ready=1, and neither held word nor the incoming word ever appears.
- Immediate mode: instr[16:0]=0x10000 -> sext_en=1 gives out_imm=0xFFFF0000; sext_en=0 gives 0x00010000.
- SKID=0, CNT_W=4: hold out_ready=0 for 20 cycles -> in_ready=0 and stall_cnt saturates at 15. Simultaneous issue and accept with out_ready=1 -> no bubble.
